sep_slots: RTL and testbench

SEP_SLOTS -- requirements
Module: sep_slots

---
 rtl/sep_pkg.sv | 26 ++
 rtl/sep_reduce.sv | 25 ++
 rtl/sep_slots.sv | 133 +++++++++++++
 tb/tb_sep_slots.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sep_pkg.sv
// Shared constants and the arrival-position to output-slot mapping used by sep_slots.
package sep_pkg;
    localparam int SEP_DEFAULT_WIDTH = 32'sd10;

    // Arrival position -> output slot index (op*ch + channel); optionally swaps the two middle groups.
    function automatic int unsigned slot_index(
        input int unsigned p,
        input int unsigned ch,
        input int unsigned ops,
        input int unsigned opswap
    );
        int unsigned grp;
        int unsigned chan;
        int unsigned op;
        grp  = p / ch;
        chan = p % ch;
        if ((opswap != 32'd0) && (ops == 32'd4) && (grp == 32'd1)) begin
            op = 32'd2;
        end else if ((opswap != 32'd0) && (ops == 32'd4) && (grp == 32'd2)) begin
            op = 32'd1;
        end else begin
            op = grp;
        end
        return op * ch + chan;
    endfunction
endpackage

// File: rtl/sep_reduce.sv
// Combinational masked AND/OR across N packed slots of WIDTH bits.
module sep_reduce #(
    parameter int WIDTH = 10,
    parameter int N     = 24
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [N-1:0]       mask_i,
    output logic [WIDTH-1:0]   and_o,
    output logic [WIDTH-1:0]   or_o
);
    // Unmasked slots are neutral: ones for AND, zeros for OR.
    always_comb begin
        and_o = {WIDTH{1'b1}};
        or_o  = {WIDTH{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (mask_i[k]) begin
                and_o = and_o & data_i[k*WIDTH +: WIDTH];
                or_o  = or_o  | data_i[k*WIDTH +: WIDTH];
            end else begin
                and_o = and_o;
                or_o  = or_o;
            end
        end
    end
endmodule

// File: rtl/sep_slots.sv
// Demultiplexes a time-multiplexed sample stream into a live slot bank and publishes
// complete, continuity-checked frames into a shadow bank with masked AND/OR reductions.
module sep_slots
    import sep_pkg::*;
#(
    parameter int WIDTH  = SEP_DEFAULT_WIDTH,
    parameter int CH     = 6,
    parameter int OPS    = 4,
    parameter int POS0   = 0,
    parameter int OPSWAP = 1,
    localparam int N     = CH * OPS,
    localparam int CW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [WIDTH-1:0]     mixed,
    input  logic [CW-1:0]        cnt,
    input  logic [N-1:0]         mask,
    output logic [N*WIDTH-1:0]   slots,
    output logic                 frame_valid,
    output logic [WIDTH-1:0]     alland,
    output logic [WIDTH-1:0]     allor,
    output logic                 sync_err
);
    localparam logic [CW:0] N_W    = (CW+1)'(N);
    localparam logic [CW:0] LAST_W = (CW+1)'(N - 1);
    localparam logic [CW:0] POS0_W = (CW+1)'(POS0);
    localparam logic [CW:0] ONE_W  = (CW+1)'(32'd1);
    localparam logic [CW:0] ZERO_W = (CW+1)'(32'd0);

    logic [N*WIDTH-1:0] live_q;
    logic [N*WIDTH-1:0] live_d;
    logic [N*WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0]   and_q;
    logic [WIDTH-1:0]   or_q;
    logic [WIDTH-1:0]   red_and_s;
    logic [WIDTH-1:0]   red_or_s;
    logic               fv_q;
    logic               err_q;
    logic               broken_q;
    logic               broken_d;
    logic               started_q;
    logic [CW:0]        prev_q;
    logic [CW:0]        sum_s;
    logic [CW:0]        pos_s;
    logic [CW:0]        exp_s;
    logic               in_range_s;
    logic               mismatch_s;
    logic               complete_s;
    logic [CW-1:0]      idx_s;

    // One extra bit keeps cnt + POS0 from wrapping before the modulo.
    assign sum_s      = {1'b0, cnt} + POS0_W;
    assign pos_s      = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
    assign in_range_s = ({1'b0, cnt} < N_W);
    assign exp_s      = (prev_q == LAST_W) ? ZERO_W : (prev_q + ONE_W);
    assign mismatch_s = started_q && (pos_s != exp_s);
    assign idx_s      = CW'(slot_index(32'(pos_s), 32'(CH), 32'(OPS), 32'(OPSWAP)));

    // Broken-frame tracking: p = 0 starts a fresh frame; the first sample after reset must be p = 0.
    always_comb begin
        broken_d = broken_q;
        if (!in_range_s) begin
            broken_d = 1'b1;
        end else if (pos_s == ZERO_W) begin
            broken_d = 1'b0;
        end else if (!started_q || mismatch_s) begin
            broken_d = 1'b1;
        end else begin
            broken_d = broken_q;
        end
    end

    assign complete_s = in_range_s && (pos_s == LAST_W) && !broken_d;

    // Live bank with this edge's sample merged in.
    always_comb begin
        live_d = live_q;
        for (int k = 0; k < N; k++) begin
            if (in_range_s && (idx_s == CW'(k))) begin
                live_d[k*WIDTH +: WIDTH] = mixed;
            end else begin
                live_d[k*WIDTH +: WIDTH] = live_q[k*WIDTH +: WIDTH];
            end
        end
    end

    sep_reduce #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_reduce (
        .data_i (live_d),
        .mask_i (mask),
        .and_o  (red_and_s),
        .or_o   (red_or_s)
    );

    // Frame state, shadow publication and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= {(N*WIDTH){1'b0}};
            shadow_q  <= {(N*WIDTH){1'b0}};
            and_q     <= {WIDTH{1'b0}};
            or_q      <= {WIDTH{1'b0}};
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            broken_q  <= 1'b0;
            started_q <= 1'b0;
            prev_q    <= ZERO_W;
        end else if (clk_en) begin
            live_q   <= live_d;
            fv_q     <= complete_s;
            err_q    <= err_q | !in_range_s | (in_range_s & mismatch_s);
            broken_q <= broken_d;
            if (in_range_s) begin
                prev_q    <= pos_s;
                started_q <= 1'b1;
            end
            if (complete_s) begin
                shadow_q <= live_d;
                and_q    <= red_and_s;
                or_q     <= red_or_s;
            end
        end
    end

    assign slots       = shadow_q;
    assign frame_valid = fv_q;
    assign alland      = and_q;
    assign allor       = or_q;
    assign sync_err    = err_q;
endmodule

// File: tb/tb_sep_slots.sv
// Directed bench for sep_slots: three configurations checked every cycle against a frame-window model.
module tb_sep_slots;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults, u1: POS0=3, u2: CH=3 OPS=2 OPSWAP=0 WIDTH=16
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [4:0]   cnt0 = '0, cnt1 = '0;
    logic [2:0]   cnt2 = '0;
    logic [9:0]   mixed0 = '0, mixed1 = '0;
    logic [15:0]  mixed2 = '0;
    logic [23:0]  mask0 = '0, mask1 = '0;
    logic [5:0]   mask2 = '0;
    logic [239:0] slots0, slots1;
    logic [95:0]  slots2;
    logic         fv0, fv1, fv2, err0, err1, err2;
    logic [9:0]   and0, or0, and1, or1;
    logic [15:0]  and2, or2;

    sep_slots u0 (.clk(clk), .rst_n(rst_n), .clk_en(en0), .mixed(mixed0), .cnt(cnt0), .mask(mask0),
                  .slots(slots0), .frame_valid(fv0), .alland(and0), .allor(or0), .sync_err(err0));
    sep_slots #(.POS0(3)) u1 (.clk(clk), .rst_n(rst_n), .clk_en(en1), .mixed(mixed1), .cnt(cnt1),
                  .mask(mask1), .slots(slots1), .frame_valid(fv1), .alland(and1), .allor(or1),
                  .sync_err(err1));
    sep_slots #(.WIDTH(16), .CH(3), .OPS(2), .OPSWAP(0)) u2 (.clk(clk), .rst_n(rst_n), .clk_en(en2),
                  .mixed(mixed2), .cnt(cnt2), .mask(mask2), .slots(slots2), .frame_valid(fv2),
                  .alland(and2), .allor(or2), .sync_err(err2));

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int pN[3], pCH[3], pPOS[3], pSW[3], pW[3];
    int winp[3][24];
    logic [15:0] winv[3][24];
    logic [15:0] es[3][24];
    logic [15:0] ea[3], eo[3];
    logic efv[3], eerr[3];
    int lastp[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wmask(input int i);
        return (pW[i] == 16) ? 16'hFFFF : 16'h03FF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 24; j++) begin
                winp[i][j] = -1;
                winv[i][j] = 16'd0;
                es[i][j]   = 16'd0;
            end
            ea[i] = 16'd0; eo[i] = 16'd0; efv[i] = 1'b0; eerr[i] = 1'b0; lastp[i] = -1;
        end
    endtask

    // A frame is published when the last N accepted samples are exactly positions 0..N-1 in order.
    task automatic model_step(input int i, input int c, input logic [15:0] v, input logic [23:0] m);
        int n, p, op, g, cc, src;
        bit done;
        n = pN[i];
        if (c >= n) begin
            eerr[i] = 1'b1;
            p = -1;
        end else begin
            p = (c + pPOS[i]) % n;
            if (lastp[i] >= 0 && p != (lastp[i] + 1) % n) eerr[i] = 1'b1;
            lastp[i] = p;
        end
        for (int j = 0; j < n - 1; j++) begin
            winp[i][j] = winp[i][j+1];
            winv[i][j] = winv[i][j+1];
        end
        winp[i][n-1] = p;
        winv[i][n-1] = v & wmask(i);
        done = 1'b1;
        for (int j = 0; j < n; j++) if (winp[i][j] != j) done = 1'b0;
        efv[i] = done;
        if (done) begin
            ea[i] = wmask(i);
            eo[i] = 16'd0;
            for (int k = 0; k < n; k++) begin
                op = k / pCH[i];
                cc = k % pCH[i];
                g  = op;
                if (pSW[i] == 1 && n / pCH[i] == 4) begin
                    if (op == 1) g = 2;
                    else if (op == 2) g = 1;
                end
                src = g * pCH[i] + cc;
                es[i][k] = winv[i][src];
                if (m[k]) begin
                    ea[i] = ea[i] & es[i][k];
                    eo[i] = eo[i] | es[i][k];
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [383:0] flat, input logic fv,
                              input logic [15:0] a, input logic [15:0] o, input logic err);
        logic [383:0] sh;
        for (int k = 0; k < pN[i]; k++) begin
            sh = flat >> (k * pW[i]);
            chk($sformatf("u%0d_slot%0d", i, k), 64'(sh[15:0] & wmask(i)), 64'(es[i][k]));
        end
        chk($sformatf("u%0d_frame_valid", i), 64'(fv), 64'(efv[i]));
        chk($sformatf("u%0d_alland", i), 64'(a), 64'(ea[i]));
        chk($sformatf("u%0d_allor", i), 64'(o), 64'(eo[i]));
        chk($sformatf("u%0d_sync_err", i), 64'(err), 64'(eerr[i]));
    endtask

    // Compare all three instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check_inst(0, {144'd0, slots0}, fv0, {6'd0, and0}, {6'd0, or0}, err0);
            check_inst(1, {144'd0, slots1}, fv1, {6'd0, and1}, {6'd0, or1}, err1);
            check_inst(2, {288'd0, slots2}, fv2, and2, or2, err2);
        end
    end

    // One clk_en cycle for instance i (i=3: idle cycle with all clk_en low).
    task automatic step(input int i, input int c, input int v, input logic [23:0] m);
        en0 = (i == 0); en1 = (i == 1); en2 = (i == 2);
        case (i)
            0: begin cnt0 = 5'(c); mixed0 = 10'(v); mask0 = m; end
            1: begin cnt1 = 5'(c); mixed1 = 10'(v); mask1 = m; end
            2: begin cnt2 = 3'(c); mixed2 = 16'(v); mask2 = m[5:0]; end
            default: ;
        endcase
        @(posedge clk);
        if (en0) model_step(0, int'(cnt0), 16'(mixed0), mask0);
        if (en1) model_step(1, int'(cnt1), 16'(mixed1), mask1);
        if (en2) model_step(2, int'(cnt2), 16'(mixed2), 24'(mask2));
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_slots_zero", 64'(|slots0), 64'd0);
        chk("rst_fv_zero", 64'(fv0), 64'd0);
        chk("rst_and_zero", 64'(and0), 64'd0);
        chk("rst_or_zero", 64'(or0), 64'd0);
        chk("rst_err_zero", 64'(err0), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        pN   = '{24, 24, 6};
        pCH  = '{6, 6, 3};
        pPOS = '{0, 3, 0};
        pSW  = '{1, 1, 0};
        pW   = '{10, 10, 16};
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_slots", 64'(|slots0), 64'd0);
        chk("reset_fv", 64'(fv0), 64'd0);
        chk("reset_err", 64'(err0 | err1 | err2), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;

        // Clean frame, all slots masked in
        for (int p = 0; p < 24; p++) step(0, p, 10 + p, 24'hFFFFFF);
        chk("lit_fv_pulse", 64'(fv0), 64'd1);
        chk("lit_slot6", 64'(slots0[69:60]), 64'd22);
        chk("lit_slot12", 64'(slots0[129:120]), 64'd16);
        chk("lit_alland_all", 64'(and0), 64'd0);
        chk("lit_allor_all", 64'(or0), 64'h3F);
        chk("lit_err_clean", 64'(err0), 64'd0);
        step(3, 0, 0, 24'd0);
        chk("lit_fv_hold", 64'(fv0), 64'd1);

        // Single-slot and empty masks
        for (int p = 0; p < 24; p++) step(0, p, 10 + p, 24'h000001);
        chk("lit_and_mask1", 64'(and0), 64'd10);
        chk("lit_or_mask1", 64'(or0), 64'd10);
        for (int p = 0; p < 24; p++) step(0, p, 10 + p, 24'h000000);
        chk("lit_and_mask0", 64'(and0), 64'h3FF);
        chk("lit_or_mask0", 64'(or0), 64'd0);

        // Counter jump 5 -> 7, then a clean frame
        for (int p = 0; p < 24; p++) if (p != 6) step(0, p, 50 + p, 24'hFFFFFF);
        chk("lit_jump_fv", 64'(fv0), 64'd0);
        chk("lit_jump_err", 64'(err0), 64'd1);
        for (int p = 0; p < 24; p++) step(0, p, 20 + p, 24'hFFFFFF);
        chk("lit_after_jump_fv", 64'(fv0), 64'd1);
        chk("lit_err_sticky", 64'(err0), 64'd1);

        // POS0=3 starting at cnt=21
        for (int k = 0; k < 24; k++) begin
            step(1, (21 + k) % 24, 200 + k, 24'hFFFFFF);
            if (k == 22) chk("lit_pos0_early", 64'(fv1), 64'd0);
        end
        chk("lit_pos0_fv", 64'(fv1), 64'd1);
        chk("lit_pos0_slot0", 64'(slots1[9:0]), 64'd200);
        chk("lit_pos0_err", 64'(err1), 64'd0);

        // Small config: out-of-range cnt, then clean frame
        step(2, 6, 16'h1234, 24'h00003F);
        chk("lit_oor_err", 64'(err2), 64'd1);
        chk("lit_oor_nowrite", 64'(|slots2), 64'd0);
        for (int p = 0; p < 6; p++) step(2, p, 100 + p, 24'h000005);
        chk("lit_small_fv", 64'(fv2), 64'd1);
        for (int k = 0; k < 6; k++) chk($sformatf("lit_small_slot%0d", k), 64'(slots2[k*16 +: 16]), 64'(100 + k));
        chk("lit_small_and", 64'(and2), 64'd100);
        chk("lit_small_or", 64'(or2), 64'd102);

        // Reset mid-frame at p=11
        for (int p = 0; p < 12; p++) step(0, p, 300 + p, 24'hFFFFFF);
        pulse_reset();
        for (int p = 12; p < 24; p++) step(0, p, 400 + p, 24'hFFFFFF);
        chk("lit_restart_fv", 64'(fv0), 64'd0);
        chk("lit_restart_err", 64'(err0), 64'd0);
        for (int p = 0; p < 24; p++) step(0, p, 500 + p, 24'hFFFFFF);
        chk("lit_post_reset_fv", 64'(fv0), 64'd1);
        chk("lit_post_reset_slot0", 64'(slots0[9:0]), 64'd500);

        step(3, 0, 0, 24'd0);
        step(3, 0, 0, 24'd0);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
